msk_fir_decim_requant: RTL and testbench
========================================

Name: msk_fir_decim_requant

Overview:
- Sits directly downstream of the I/Q channel lowpass FIR (fir_lpf) in the MSK receive path; one instance per channel.
- Consumes the FIR's 32-bit full-precision output stream and decimates it by DECIM with a selectable phase.
- Rounds, shifts and saturates each kept sample to OUT_W bits, then buffers it in a small FIFO.
- Drives an AXI-stream master with backpressure. The FIR output has no tready, so the input side of this block never stalls.

Parameters:
IN_W, 32, input sample width (signed, FIR output)
OUT_W, 16, output sample width (signed)
DECIM, 4, decimation factor, >=1
SHIFT, 15, right-shift applied after rounding (coefficient fractional bits), 1..IN_W-1
FIFO_DEPTH, 8, output FIFO depth in entries, power of 2

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  input beat valid; no tready, every valid beat is consumed
s_axis_tdata  in  IN_W  signed FIR output sample
phase_sel  in  max(1,$clog2(DECIM))  decimation phase, 0..DECIM-1
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  OUT_W  signed requantized sample
clr_flags  in  1  one-cycle pulse that clears the sticky flags
sat_flag  out  1  sticky: at least one kept sample saturated
ovf_flag  out  1  sticky: at least one kept sample was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high): all of the following are 0: phase counter, pipeline valids, FIFO pointers/count, m_axis_tvalid, m_axis_tdata, sat_flag, ovf_flag.
- A reset mid-operation discards all in-flight and buffered samples. There are no partial outputs after reset.
- Phase counter:
  - Increments on each cycle with s_axis_tvalid=1 and wraps from DECIM-1 to 0.
  - A beat is kept when the counter value equals phase_sel.
  - phase_sel is read live each beat. If phase_sel>=DECIM, no sample is kept.
  - DECIM=1 keeps every beat.
- Stage 1 (registered): computes sum = tdata + 2^(SHIFT-1) in IN_W+1 bits, then applies an arithmetic right shift by SHIFT. Rounding is round-half-up (toward +inf).
- Stage 2 (registered): saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A clipped value sets sat_flag. The result is then written to the FIFO.
- Latency:
  - A kept beat sampled on edge E is written to the FIFO on edge E+1.
  - If the FIFO was empty, m_axis_tvalid is high from edge E+2 (first-word fall-through).
  - Sustained throughput is 1 sample/clk in and 1 sample/clk out.
- AXI master rules:
  - A transfer occurs on an edge where tvalid && tready.
  - Once tvalid is high, tvalid and tdata hold stable until that transfer.
  - tvalid is never dependent combinationally on tready.
- FIFO full when a write arrives:
  - If a read occurs on the same edge, the write is accepted and the count is unchanged.
  - Otherwise the new sample is dropped, ovf_flag is set, and FIFO contents are unchanged (oldest data preserved).
- FIFO empty: m_axis_tvalid=0. A simultaneous write and read on an empty FIFO cannot occur, because there is no bypass.
- Pointers wrap modulo FIFO_DEPTH. The count is kept separately, 0..FIFO_DEPTH.
- Sticky flags: clr_flags clears them on the next edge. If a set event occurs in the same cycle as clr_flags, the set wins.

Decomposition:
- Package msk_dsp_pkg holds:
  - localparam helpers for OUT_MAX/OUT_MIN derived from OUT_W;
  - a function round_shift_sat(value, shift, out_w) returning the saturated result and a sat bit;
  - a typedef for the kept-sample pipeline struct {valid, data}.
- Sub-module msk_axis_fifo: a parameterized synchronous FWFT FIFO (WIDTH, DEPTH) with a wr_en/full/overflow-drop port and an AXI-stream read side. It is reusable by the Q channel and the timing-recovery stage.

Test Plan:
- Reset: assert reset for 5 clk mid-stream with 3 samples buffered -> after release, m_axis_tvalid=0, sat_flag=0, ovf_flag=0, and the first output is the first sample kept after reset.
- Decimation: DECIM=4, tready=1, feed continuously k*32768 for k=0..15.
  - phase_sel=0 -> outputs 0,4,8,12 with tvalid first high 2 edges after k=0 is sampled.
  - phase_sel=2 -> outputs 2,6,10,14.
- Rounding (DECIM=1): inputs 16384, 16383, -16384, -16385 -> outputs 1, 0, 0, -1; sat_flag stays 0.
- Saturation (DECIM=1): 32'h7FFFFFFF -> 32767 and 32'h80000000 -> -32768, with sat_flag=1. Then clr_flags pulse -> sat_flag=0.
- Overflow (DECIM=4, phase_sel=0): tready=0, feed 40 continuous beats with data k*32768 -> ovf_flag=1. Then tready=1 -> exactly 8 outputs 0,4,...,28 in order, then tvalid=0.
- Full with simultaneous read: fill to 8, then hold tready=1 while feeding kept beats at 1 per 4 clk -> no drop, ovf_flag=0. With random tready toggling, every output holds tdata stable while tvalid=1 && tready=0.

Source files
------------

// File: rtl/msk_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Package : msk_dsp_pkg
// Shared requantisation helpers and pipeline types for the MSK receive DSP.
// Rev     : 1.0
// ============================================================================
package msk_dsp_pkg;

    localparam int c_CALC_W = 64;

    typedef logic signed [c_CALC_W-1:0] calc_t;

    typedef struct packed {
        logic  valid;
        calc_t data;
    } kept_t;

    typedef struct packed {
        logic  sat;
        calc_t data;
    } sat_res_t;

    function automatic calc_t out_max(input int out_w);
        return (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t out_min(input int out_w);
        return -(calc_t'(1) <<< (out_w - 1));
    endfunction

    // Round half toward +inf, then arithmetic shift.
    function automatic calc_t round_shift(input calc_t value, input int shift);
        calc_t sum;
        sum = value + (calc_t'(1) <<< (shift - 1));
        return sum >>> shift;
    endfunction

    function automatic sat_res_t saturate(input calc_t value, input int out_w);
        sat_res_t res;
        res.sat  = 1'b0;
        res.data = value;
        if (value > out_max(out_w)) begin
            res.sat  = 1'b1;
            res.data = out_max(out_w);
        end else if (value < out_min(out_w)) begin
            res.sat  = 1'b1;
            res.data = out_min(out_w);
        end
        return res;
    endfunction

    function automatic sat_res_t round_shift_sat(input calc_t value, input int shift,
                                                 input int out_w);
        return saturate(round_shift(value, shift), out_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msk_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module : msk_axis_fifo
// Synchronous FWFT FIFO; writes to a full FIFO without a same-edge read drop.
// Rev    : 1.0
// ============================================================================
module msk_axis_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             overflow,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             tvalid_q, tvalid_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             pop, push, load, mem_has;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // count_q includes the entry held in the output register.
    always_comb begin
        pop      = tvalid_q && m_axis_tready;
        push     = wr_en && ((count_q != CW'(DEPTH)) || pop);
        overflow = wr_en && !push;
        mem_has  = count_q > CW'(tvalid_q);
        load     = mem_has && (!tvalid_q || pop);
        tvalid_d = load || (tvalid_q && !pop);
        tdata_d  = load ? mem_q[rd_ptr_q] : tdata_q;
        rd_ptr_d = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full          = (count_q == CW'(DEPTH));
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;

endmodule
`default_nettype wire

// File: rtl/msk_fir_decim_requant.sv
`default_nettype none
// ============================================================================
// Module : msk_fir_decim_requant
// FIR output decimator with round/shift/saturate requantiser and AXIS FIFO.
// Rev    : 1.0
// ============================================================================
module msk_fir_decim_requant
    import msk_dsp_pkg::*;
#(
    parameter  int IN_W       = 32,
    parameter  int OUT_W      = 16,
    parameter  int DECIM      = 4,
    parameter  int SHIFT      = 15,
    parameter  int FIFO_DEPTH = 8,
    localparam int PH_W       = (DECIM > 1) ? $clog2(DECIM) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_axis_tvalid,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic [PH_W-1:0]  phase_sel,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    input  logic             clr_flags,
    output logic             sat_flag,
    output logic             ovf_flag
);

    logic [PH_W-1:0] phase_q, phase_d;
    kept_t           s1_q, s1_d;
    logic            sat_q, sat_d;
    logic            ovf_q, ovf_d;
    sat_res_t        s2_res;
    logic            fifo_ovf;
    logic            fifo_full;
    logic            unused_bits;

    always_comb begin
        phase_d = phase_q;
        if (s_axis_tvalid) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
        end

        // An out-of-range phase_sel never matches the counter, so nothing is kept.
        s1_d.valid = s_axis_tvalid && (phase_q == phase_sel);
        s1_d.data  = round_shift(calc_t'($signed(s_axis_tdata)), SHIFT);

        s2_res = saturate(s1_q.data, OUT_W);

        sat_d = clr_flags ? 1'b0 : sat_q;
        if (s1_q.valid && s2_res.sat) begin
            sat_d = 1'b1;
        end
        ovf_d = clr_flags ? 1'b0 : ovf_q;
        if (fifo_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            s1_q    <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            s1_q    <= s1_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    msk_axis_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (s1_q.valid),
        .wr_data       (s2_res.data[OUT_W-1:0]),
        .full          (fifo_full),
        .overflow      (fifo_ovf),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
    );

    assign sat_flag    = sat_q;
    assign ovf_flag    = ovf_q;
    assign unused_bits = &{1'b0, s2_res.data[c_CALC_W-1:OUT_W], fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_msk_fir_decim_requant.sv
`default_nettype none
// ============================================================================
// Module : tb_msk_fir_decim_requant
// Bench for msk_fir_decim_requant: DECIM=4 and DECIM=1 instances vs a queue model.
// Rev    : 1.0
// ============================================================================
module tb_msk_fir_decim_requant;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, s_tvalid, tready, clr, sel, ph1;
    logic [31:0] s_tdata;
    logic [1:0]  ph4;

    logic               tv4, tv1, sat4, sat1, ovf4, ovf1;
    logic signed [15:0] td4, td1;
    logic               tv, sat, ovf;
    logic signed [15:0] td;

    assign tv  = sel ? tv1  : tv4;
    assign td  = sel ? td1  : td4;
    assign sat = sel ? sat1 : sat4;
    assign ovf = sel ? ovf1 : ovf4;

    msk_fir_decim_requant #(.IN_W(32), .OUT_W(16), .DECIM(4), .SHIFT(15), .FIFO_DEPTH(8)) dut4 (
        .clk(clk), .reset(reset), .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tdata(s_tdata),
        .phase_sel(ph4), .m_axis_tvalid(tv4), .m_axis_tready(tready & ~sel),
        .m_axis_tdata(td4), .clr_flags(clr), .sat_flag(sat4), .ovf_flag(ovf4));

    msk_fir_decim_requant #(.IN_W(32), .OUT_W(16), .DECIM(1), .SHIFT(15), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .s_axis_tvalid(s_tvalid & sel), .s_axis_tdata(s_tdata),
        .phase_sel(ph1), .m_axis_tvalid(tv1), .m_axis_tready(tready & sel),
        .m_axis_tdata(td1), .clr_flags(clr), .sat_flag(sat1), .ovf_flag(ovf1));

    int checks = 0;
    int errors = 0;

    // Reference model state: kept samples, queue of stored values with write edge.
    int     ecur, beats;
    bit     pend_v, m_sat, m_ovf;
    longint pend_x;
    longint qv[$];
    int     qt[$];
    longint got[$];

    typedef struct {
        logic [31:0] din;
        longint      dout;
        bit          dsat;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, ecur);
        end
    endtask

    // floor((x + 2^14) / 2^15) clamped to 16-bit signed.
    function automatic longint ref_rq(input longint x, output bit clip);
        longint num, q;
        num = x + 16384;
        q   = num / 32768;
        if ((num % 32768) != 0 && num < 0) q = q - 1;
        clip = 1'b0;
        if (q > 32767) begin
            q = 32767; clip = 1'b1;
        end else if (q < -32768) begin
            q = -32768; clip = 1'b1;
        end
        return q;
    endfunction

    task automatic model_step();
        bit     vis, pop, clip, set_s, set_o;
        longint y;
        int     d, ph;
        ecur++;
        if (reset) begin
            qv.delete(); qt.delete();
            pend_v = 0; beats = 0; m_sat = 0; m_ovf = 0;
            return;
        end
        d   = sel ? 1 : 4;
        ph  = sel ? int'(ph1) : int'(ph4);
        vis = (qv.size() > 0) && (qt[0] + 2 <= ecur);
        pop = vis && tready;
        if (pop) begin
            void'(qv.pop_front());
            void'(qt.pop_front());
        end
        set_s = 0; set_o = 0;
        if (pend_v) begin
            y     = ref_rq(pend_x, clip);
            set_s = clip;
            if (qv.size() < 8) begin
                qv.push_back(y);
                qt.push_back(ecur);
            end else begin
                set_o = 1;
            end
        end
        if (clr) begin m_sat = 0; m_ovf = 0; end
        if (set_s) m_sat = 1;
        if (set_o) m_ovf = 1;
        pend_v = s_tvalid && ((beats % d) == ph);
        pend_x = longint'($signed(s_tdata));
        if (s_tvalid) beats++;
    endtask

    task automatic cycle();
        bit     ptv, prdy, prst, vis;
        longint ptd;
        ptv = tv; prdy = tready; ptd = td; prst = reset;
        @(posedge clk);
        if (ptv && prdy) got.push_back(ptd);
        model_step();
        #1;
        vis = (qv.size() > 0) && (qt[0] + 1 <= ecur);
        chk("tvalid", longint'(tv), longint'(vis));
        if (vis) chk("tdata", longint'(td), qv[0]);
        chk("sat_flag", longint'(sat), longint'(m_sat));
        chk("ovf_flag", longint'(ovf), longint'(m_ovf));
        if (ptv && !prdy && !prst) begin
            chk("hold_tvalid", longint'(tv), 1);
            chk("hold_tdata", longint'(td), ptd);
        end
    endtask

    task automatic reset_dut(input int n);
        s_tvalid = 0; clr = 0; reset = 1;
        repeat (n) cycle();
        reset = 0;
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 1048576)) - 32'd524288;
            2:       return 32'($urandom_range(0, 16777215)) << 8;
            default: return 32'h3FFF0000 + 32'($urandom_range(0, 131071));
        endcase
    endfunction

    task automatic run_decim(input int ph);
        int e0, first;
        reset_dut(2);
        ph4 = 2'(ph); tready = 1; got.delete();
        e0 = 0; first = -1;
        for (int k = 0; k < 16; k++) begin
            s_tvalid = 1; s_tdata = 32'(k * 32768);
            cycle();
            if (k == 0) e0 = ecur;
            if (tv && first < 0) first = ecur;
        end
        s_tvalid = 0;
        repeat (6) begin
            cycle();
            if (tv && first < 0) first = ecur;
        end
        chk("decim_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("decim_out", got[i], ph + 4 * i);
        chk("decim_latency", first - e0, ph + 2);
    endtask

    initial begin
        vecs[0] = '{32'd16384,     1,      0};
        vecs[1] = '{32'd16383,     0,      0};
        vecs[2] = '{32'hFFFFC000,  0,      0};
        vecs[3] = '{32'hFFFFBFFF, -1,      0};
        vecs[4] = '{32'h3FFF8000,  32767,  0};
        vecs[5] = '{32'hC0000000, -32768,  0};
        vecs[6] = '{32'h3FFFC000,  32767,  1};
        vecs[7] = '{32'h80000000, -32768,  1};
        vecs[8] = '{32'h7FFFFFFF,  32767,  1};

        sel = 0; reset = 1; s_tvalid = 0; s_tdata = 0; ph4 = 0; ph1 = 0;
        tready = 1; clr = 0; ecur = 0; beats = 0; pend_v = 0; pend_x = 0;
        m_sat = 0; m_ovf = 0;
        reset_dut(3);
        chk("rst_tvalid4", longint'(tv4), 0);
        chk("rst_tdata4", longint'(td4), 0);
        chk("rst_flags4", longint'({sat4, ovf4}), 0);
        chk("rst_tvalid1", longint'(tv1), 0);
        chk("rst_tdata1", longint'(td1), 0);

        // Decimation, two phases.
        run_decim(0);
        run_decim(2);

        // Overflow: 40 beats into a stalled sink, then drain.
        reset_dut(2);
        ph4 = 0; tready = 0;
        for (int k = 0; k < 40; k++) begin
            s_tvalid = 1; s_tdata = 32'(k * 32768); cycle();
        end
        s_tvalid = 0; repeat (3) cycle();
        chk("ovf_set", longint'(ovf), 1);
        tready = 1; got.delete();
        repeat (15) cycle();
        chk("ovf_drain_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("ovf_drain_out", got[i], 4 * i);
        chk("ovf_drained_empty", longint'(tv), 0);

        // Full FIFO with a read on the same edge as the write.
        reset_dut(2);
        ph4 = 0; tready = 0;
        for (int k = 0; k < 33; k++) begin
            s_tvalid = 1; s_tdata = 32'(k * 32768); cycle();
        end
        tready = 1;
        for (int k = 33; k < 64; k++) begin
            s_tdata = 32'(k * 32768); cycle();
        end
        chk("full_rd_no_ovf", longint'(ovf), 0);
        for (int k = 0; k < 200; k++) begin
            s_tvalid = 1; s_tdata = 32'((64 + k) * 32768);
            tready = ($urandom_range(0, 1) == 1);
            cycle();
        end

        // Reset mid-stream with three samples buffered.
        reset_dut(2);
        ph4 = 0; tready = 0;
        for (int k = 0; k < 12; k++) begin
            s_tvalid = 1; s_tdata = 32'(k * 32768); cycle();
        end
        s_tvalid = 0; cycle(); cycle();
        chk("pre_rst_tvalid", longint'(tv), 1);
        s_tvalid = 1; s_tdata = 32'(900 * 32768); reset = 1;
        repeat (5) cycle();
        reset = 0;
        chk("post_rst_tvalid", longint'(tv), 0);
        chk("post_rst_tdata", longint'(td), 0);
        chk("post_rst_flags", longint'({sat, ovf}), 0);
        tready = 1; got.delete();
        for (int k = 0; k < 8; k++) begin
            s_tdata = 32'((500 + k) * 32768); cycle();
        end
        s_tvalid = 0; repeat (6) cycle();
        chk("post_rst_count", got.size(), 2);
        if (got.size() > 0) chk("post_rst_first", got[0], 500);

        // Random traffic on DECIM=4.
        reset_dut(2);
        for (int k = 0; k < 500; k++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = rnd_data();
            tready   = ($urandom_range(0, 2) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) ph4 = 2'($urandom_range(0, 3));
            cycle();
        end
        clr = 0;

        // DECIM=1: rounding and saturation table.
        sel = 1; ph1 = 0;
        reset_dut(2);
        tready = 1;
        foreach (vecs[i]) begin
            clr = 1; cycle(); clr = 0;
            s_tvalid = 1; s_tdata = vecs[i].din; cycle();
            s_tvalid = 0; cycle(); cycle();
            chk("vec_tvalid", longint'(tv), 1);
            chk("vec_tdata", longint'(td), vecs[i].dout);
            chk("vec_sat", longint'(sat), longint'(vecs[i].dsat));
            cycle();
        end
        clr = 1; cycle(); clr = 0;
        chk("sat_cleared", longint'(sat), 0);

        // DECIM=1 with phase_sel out of range keeps nothing.
        ph1 = 1; got.delete();
        for (int k = 0; k < 6; k++) begin
            s_tvalid = 1; s_tdata = 32'(k * 32768); cycle();
        end
        s_tvalid = 0; repeat (4) cycle();
        chk("phase_oor_count", got.size(), 0);

        // Random traffic on DECIM=1.
        reset_dut(2);
        ph1 = 0;
        for (int k = 0; k < 400; k++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = rnd_data();
            tready   = ($urandom_range(0, 2) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) ph1 = ~ph1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
